// File: rtl/eater_bus_cycle_gen_if.sv
// Request/response and 6502-style bus signals of the bus cycle generator.
// master = cycle generator, slave = requester plus the addressed device.
interface eater_bus_cycle_gen_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_we;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] bus_addr;
  logic        bus_rwb;
  logic        bus_phi2;
  logic [7:0]  bus_data_out;
  logic        bus_data_oe;
  logic [7:0]  bus_data_in;
  logic        bus_rdy;

  modport master (
    input  req_valid, req_addr, req_we, req_wdata, bus_data_in, bus_rdy,
    output req_ready, rsp_valid, rsp_rdata,
           bus_addr, bus_rwb, bus_phi2, bus_data_out, bus_data_oe
  );

  modport slave (
    output req_valid, req_addr, req_we, req_wdata, bus_data_in, bus_rdy,
    input  req_ready, rsp_valid, rsp_rdata,
           bus_addr, bus_rwb, bus_phi2, bus_data_out, bus_data_oe
  );
endinterface

// File: rtl/eater_bus_cycle_gen.sv
// 6502-style bus initiator: one request becomes an IDLE->PHI1->PHI2->HOLD cycle.
// Optional macro RDY_EN: bus_rdy low on the last PHI2 cycle stretches PHI2.
module eater_bus_cycle_gen #(
  parameter int PHI_DIV = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  eater_bus_cycle_gen_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_PHI1, S_PHI2, S_HOLD} state_e;

  localparam logic [3:0] CNT_LAST = 4'(PHI_DIV - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        rwb_q, rwb_d;
  logic        phi2_q, phi2_d;
  logic        oe_q, oe_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        last;
  logic        rdy_ok;

`ifdef RDY_EN
  assign rdy_ok = bus.bus_rdy;
`else
  logic unused_rdy;
  assign unused_rdy = bus.bus_rdy;
  assign rdy_ok     = 1'b1;
`endif

  assign last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rwb_d       = rwb_q;
    phi2_d      = phi2_q;
    oe_d        = oe_q;
    dout_d      = dout_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          rwb_d   = ~bus.req_we;
          dout_d  = bus.req_wdata;
          cnt_d   = '0;
          state_d = S_PHI1;
        end
      end
      S_PHI1: begin
        if (last) begin
          state_d = S_PHI2;
          cnt_d   = '0;
          phi2_d  = 1'b1;
          oe_d    = ~rwb_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_PHI2: begin
        // Outputs are registered, so HOLD values are set on the edge leaving PHI2.
        if (last) begin
          if (rdy_ok) begin
            state_d     = S_HOLD;
            cnt_d       = '0;
            phi2_d      = 1'b0;
            oe_d        = 1'b0;
            rsp_valid_d = 1'b1;
            if (rwb_q) rdata_d = bus.bus_data_in;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
        rwb_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rwb_q       <= 1'b1;
      phi2_q      <= 1'b0;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rwb_q       <= rwb_d;
      phi2_q      <= phi2_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.bus_addr     = addr_q;
  assign bus.bus_rwb      = rwb_q;
  assign bus.bus_phi2     = phi2_q;
  assign bus.bus_data_out = dout_q;
  assign bus.bus_data_oe  = oe_q;

endmodule

// File: tb/tb_eater_bus_cycle_gen.sv
// Bench for eater_bus_cycle_gen: instance 0 uses PHI_DIV=2, instance 1 PHI_DIV=1.
// A cycle-offset model predicts every output on every falling clock edge.
module tb_eater_bus_cycle_gen;

`ifdef RDY_EN
  localparam bit RDY = 1'b1;
`else
  localparam bit RDY = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic        req_valid [2];
  logic [15:0] req_addr [2];
  logic        req_we [2];
  logic [7:0]  req_wdata [2];
  logic [7:0]  bus_data_in [2];
  logic        bus_rdy [2];

  logic        o_ready [2];
  logic        o_rsp [2];
  logic [7:0]  o_rdata [2];
  logic [15:0] o_addr [2];
  logic        o_rwb [2];
  logic        o_phi2 [2];
  logic [7:0]  o_dout [2];
  logic        o_oe [2];

  eater_bus_cycle_gen_if if0 ();
  eater_bus_cycle_gen_if if1 ();

  eater_bus_cycle_gen #(.PHI_DIV(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  eater_bus_cycle_gen #(.PHI_DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.req_valid   = req_valid[0];
  assign if0.req_addr    = req_addr[0];
  assign if0.req_we      = req_we[0];
  assign if0.req_wdata   = req_wdata[0];
  assign if0.bus_data_in = bus_data_in[0];
  assign if0.bus_rdy     = bus_rdy[0];
  assign if1.req_valid   = req_valid[1];
  assign if1.req_addr    = req_addr[1];
  assign if1.req_we      = req_we[1];
  assign if1.req_wdata   = req_wdata[1];
  assign if1.bus_data_in = bus_data_in[1];
  assign if1.bus_rdy     = bus_rdy[1];

  assign o_ready[0] = if0.req_ready;    assign o_ready[1] = if1.req_ready;
  assign o_rsp[0]   = if0.rsp_valid;    assign o_rsp[1]   = if1.rsp_valid;
  assign o_rdata[0] = if0.rsp_rdata;    assign o_rdata[1] = if1.rsp_rdata;
  assign o_addr[0]  = if0.bus_addr;     assign o_addr[1]  = if1.bus_addr;
  assign o_rwb[0]   = if0.bus_rwb;      assign o_rwb[1]   = if1.bus_rwb;
  assign o_phi2[0]  = if0.bus_phi2;     assign o_phi2[1]  = if1.bus_phi2;
  assign o_dout[0]  = if0.bus_data_out; assign o_dout[1]  = if1.bus_data_out;
  assign o_oe[0]    = if0.bus_data_oe;  assign o_oe[1]    = if1.bus_data_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pdiv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Model: k = clk cycles since the accept edge; PHI1 is k=1..P, PHI2 is
  // k=P+1..2P+w (w = wait cycles), the response cycle is k=2P+w+1.
  bit          m_busy [2];
  int          m_k [2];
  int          m_w [2];
  logic [15:0] m_addr [2];
  logic        m_we [2];
  logic [7:0]  m_wdata [2];
  logic [7:0]  m_rdata [2];
  int          acc0 [$];
  int          acc1 [$];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i]  <= 1'b0;
        m_k[i]     <= 0;
        m_w[i]     <= 0;
        m_addr[i]  <= '0;
        m_we[i]    <= 1'b0;
        m_wdata[i] <= '0;
        m_rdata[i] <= '0;
      end else if (!m_busy[i]) begin
        if (req_valid[i]) begin
          m_busy[i]  <= 1'b1;
          m_k[i]     <= 1;
          m_w[i]     <= 0;
          m_addr[i]  <= req_addr[i];
          m_we[i]    <= req_we[i];
          m_wdata[i] <= req_wdata[i];
          if (i == 0) acc0.push_back(cyc);
          else        acc1.push_back(cyc);
        end
      end else if (m_k[i] == 2 * pdiv(i) + m_w[i]) begin
        m_k[i] <= m_k[i] + 1;
        if (RDY && !bus_rdy[i]) m_w[i] <= m_w[i] + 1;
        else if (!m_we[i])      m_rdata[i] <= bus_data_in[i];
      end else if (m_k[i] > 2 * pdiv(i) + m_w[i]) begin
        m_busy[i] <= 1'b0;
      end else begin
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  function automatic bit exp_phi2(input int i);
    return m_busy[i] && (m_k[i] > pdiv(i)) && (m_k[i] <= 2 * pdiv(i) + m_w[i]);
  endfunction

  function automatic bit exp_rsp(input int i);
    return m_busy[i] && (m_k[i] == 2 * pdiv(i) + m_w[i] + 1);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d.req_ready", i), o_ready[i], !m_busy[i]);
        check($sformatf("u%0d.phi2", i),      o_phi2[i],  exp_phi2(i));
        check($sformatf("u%0d.rwb", i),       o_rwb[i],   m_busy[i] ? !m_we[i] : 1);
        check($sformatf("u%0d.oe", i),        o_oe[i],    m_we[i] && exp_phi2(i));
        check($sformatf("u%0d.rsp_valid", i), o_rsp[i],   exp_rsp(i));
        check($sformatf("u%0d.addr", i),      o_addr[i],  m_addr[i]);
        check($sformatf("u%0d.data_out", i),  o_dout[i],  m_wdata[i]);
        check($sformatf("u%0d.rdata", i),     o_rdata[i], m_rdata[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sweep_addr(input int j);
    case (j)
      0:       return 16'h0000;
      1:       return 16'h4000;
      2:       return 16'h6000;
      default: return 16'h8000;
    endcase
  endfunction

  int n;
  int nphi;
  bit got;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_we[i] = 1'b0;
      req_wdata[i] = '0; bus_data_in[i] = '0; bus_rdy[i] = 1'b1;
    end
    tick(); tick();
    chk_en = 1'b1;
    check("rst_ready", o_ready[0], 1);
    check("rst_rwb",   o_rwb[0],   1);
    check("rst_phi2",  o_phi2[0],  0);
    check("rst_oe",    o_oe[0],    0);
    check("rst_addr",  o_addr[0],  0);
    check("rst_rsp",   o_rsp[0],   0);
    check("rst_rdata", o_rdata[0], 0);
    rst_n = 1'b1;
    tick();

    // Directed read 0x6000 returning 0xA5
    req_valid[0] = 1'b1; req_addr[0] = 16'h6000; req_we[0] = 1'b0;
    req_wdata[0] = 8'h00; bus_data_in[0] = 8'hA5;
    tick();
    req_valid[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check("rd_phi2", o_phi2[0], (k == 3 || k == 4));
      check("rd_rwb",  o_rwb[0],  1);
      check("rd_oe",   o_oe[0],   0);
      check("rd_rsp",  o_rsp[0],  (k == 5));
      if (k == 5) check("rd_rdata", o_rdata[0], 8'hA5);
      tick();
    end

    // Directed write 0x0123 <- 0x3C
    req_valid[0] = 1'b1; req_addr[0] = 16'h0123; req_we[0] = 1'b1;
    req_wdata[0] = 8'h3C; bus_data_in[0] = 8'h77;
    tick();
    req_valid[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check("wr_rwb",  o_rwb[0],  0);
      check("wr_oe",   o_oe[0],   (k == 3 || k == 4));
      check("wr_dout", o_dout[0], 8'h3C);
      check("wr_addr", o_addr[0], 16'h0123);
      check("wr_rsp",  o_rsp[0],  (k == 5));
      if (k == 5) check("wr_rdata_kept", o_rdata[0], 8'hA5);
      tick();
    end
    check("wr_idle_rwb", o_rwb[0], 1);

    // req_valid held high: accepts must be 6 cycles apart
    n = acc0.size();
    req_valid[0] = 1'b1; req_addr[0] = 16'h2000; req_we[0] = 1'b0;
    for (int c = 0; c < 9; c++) begin
      bus_data_in[0] = 8'($urandom);
      tick();
    end
    req_valid[0] = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    check("b2b_accepts", acc0.size() - n, 2);
    if (acc0.size() >= n + 2) check("b2b_spacing", acc0[n + 1] - acc0[n], 6);

    // Reset while PHI2 is high
    req_valid[0] = 1'b1; req_addr[0] = 16'h6000; req_we[0] = 1'b1; req_wdata[0] = 8'h99;
    tick();
    req_valid[0] = 1'b0;
    tick(); tick();
    check("pre_rst_phi2", o_phi2[0], 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_phi2", o_phi2[0], 0);
    check("mid_rst_rwb",  o_rwb[0],  1);
    check("mid_rst_oe",   o_oe[0],   0);
    check("mid_rst_addr", o_addr[0], 0);
    check("mid_rst_rsp",  o_rsp[0],  0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", o_ready[0], 1);
    tick(); tick();

    // Read with bus_rdy low for three cycles at the end of PHI2
    req_valid[0] = 1'b1; req_addr[0] = 16'h6000; req_we[0] = 1'b0; bus_data_in[0] = 8'h11;
    tick();
    req_valid[0] = 1'b0;
    nphi = 0; got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      bus_rdy[0]     = !(k >= 4 && k <= 6);
      bus_data_in[0] = (k >= 7) ? 8'h5A : 8'h11;
      if (o_phi2[0]) nphi++;
      if (o_rsp[0]) got = 1'b1;
      tick();
    end
    bus_rdy[0] = 1'b1;
    check("rdy_rsp_seen", got, 1);
    check("rdy_phi2_len", nphi, RDY ? 5 : 2);
    check("rdy_rdata", o_rdata[0], RDY ? 8'h5A : 8'h11);
    tick(); tick();

    // PHI_DIV=1 sweep of reads and writes over four regions
    n = acc1.size();
    req_valid[1] = 1'b1;
    for (int c = 0; c < 32; c++) begin
      req_addr[1]    = sweep_addr((c / 4) / 2);
      req_we[1]      = 1'((c / 4) % 2);
      req_wdata[1]   = 8'(8'h40 + c / 4);
      bus_data_in[1] = 8'($urandom);
      tick();
    end
    req_valid[1] = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check("sweep_accepts", acc1.size() - n, 8);
    if (acc1.size() >= n + 8)
      for (int j = 0; j < 7; j++) check("sweep_spacing", acc1[n + j + 1] - acc1[n + j], 4);

    // Random traffic on both instances, with one reset pulse
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        req_valid[i]   = 1'($urandom_range(0, 1));
        req_addr[i]    = 16'($urandom);
        req_we[i]      = 1'($urandom_range(0, 1));
        req_wdata[i]   = 8'($urandom);
        bus_data_in[i] = 8'($urandom);
        bus_rdy[i]     = ($urandom_range(0, 3) != 0);
      end
      if (c == 300) rst_n = 1'b0;
      if (c == 303) rst_n = 1'b1;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      bus_rdy[i]   = 1'b1;
    end
    for (int c = 0; c < 10; c++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
